// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_rx and uart_tx.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - serial line levels (idle, start bit, stop bit)
//   - default frame timing parameters
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for a single asynchronous input.
// Ports:
//   i_clk     destination clock
//   i_rst     synchronous active-high reset; both flops load RESET_VAL
//   i_async   asynchronous input
//   o_sync    synchronised output (2 cycles of latency)
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : uart_sync

// File: rtl/uart_rx.sv
// uart_rx: serial receiver (start bit 0, DATA_BITS data bits LSB first,
// one stop bit 1). The line is resynchronised, each bit is sampled at
// mid-period and a low stop bit is reported as a framing error.
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset
//   ser_in     asynchronous serial line, idles high
//   data       last good byte; bit 0 is the first bit received
//   done       one-cycle pulse when data is updated
//   frame_err  one-cycle pulse when the stop bit sampled low
//   busy       high in every state other than IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 ser_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  // START waits half a bit so that all later samples land mid-bit.
  localparam logic [CNT_W-1:0] C_HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 w_rx;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_ferr;

  // Reset to the idle line level so leaving reset never looks like a start.
  uart_sync #(.RESET_VAL(LINE_IDLE)) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (ser_in),
    .o_sync  (w_rx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      // Pulses default low; they are raised for exactly one cycle below.
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (w_rx == START_BIT) r_state <= ST_START;
        end
        ST_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            // A start bit that has vanished by mid-bit is a glitch.
            r_state <= (w_rx == START_BIT) ? ST_DATA : ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            // Shift in from the MSB side so the first bit ends up in bit 0.
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            if (r_bit == C_LAST_BIT) begin
              r_bit   <= '0;
              r_state <= ST_STOP;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (w_rx == STOP_BIT) begin
              r_data  <= r_shift;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          // A held-low line (break) must not be read as a new start bit.
          r_cnt <= '0;
          if (w_rx == LINE_IDLE) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign done      = r_done;
  assign frame_err = r_ferr;
  assign busy      = (r_state != ST_IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized, scoreboard-checked bench for uart_rx.
// The driver serialises bytes and pushes the expected outcome (byte or
// framing error, plus the cycle by which it must appear) into a queue;
// an independent monitor pops and compares whenever done/frame_err fires.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int H   = (CPB - 1) / 2;
  localparam int LAT = H + (DB + 1) * CPB + 3;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ser_in = 1'b1;
  logic [DB-1:0] data;
  logic         done;
  logic         frame_err;
  logic         busy;

  exp_t       sb_q[$];
  logic [7:0] last_good = 8'h00;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         prev_pulse = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .ser_in    (ser_in),
    .data      (data),
    .done      (done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Serialise one frame. Bits change on the falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit push, input bit chk_busy);
    logic [9:0] bits;
    exp_t e;
    @(negedge clk);
    bits = {stop, b, 1'b0};
    if (push) begin
      e.is_err = (stop == 1'b0);
      // A framing error leaves data at the last good byte.
      e.data   = e.is_err ? last_good : b;
      e.due    = cyc + 1 + LAT;
      if (!e.is_err) last_good = b;
      sb_q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      ser_in = bits[i];
      for (int c = 0; c < CPB; c++) begin
        if (chk_busy && i == 4 && c == CPB / 2)
          check(busy === 1'b1, "busy_mid_frame", busy, 1);
        if (c != CPB - 1) @(negedge clk);
      end
      if (i != 9) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    ser_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every output event against the scoreboard.
  always @(negedge clk) begin
    if (!rst && (done || frame_err)) begin
      exp_t e;
      check(!(done && frame_err), "done_and_ferr_together", {done, frame_err}, 0);
      check(!prev_pulse, "pulse_width", prev_pulse, 0);
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_output", {done, frame_err}, 0);
      end else begin
        e = sb_q.pop_front();
        check(frame_err == e.is_err, "event_kind", frame_err, e.is_err);
        check(data === e.data, "data", data, e.data);
        check((cyc >= e.due - 1) && (cyc <= e.due + 1), "latency", cyc, e.due);
      end
    end
    prev_pulse = !rst && (done || frame_err);
  end

  initial begin
    logic [7:0] rb;
    int         waited;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check(data === 8'h00, "reset_data", data, 0);
    check(done === 1'b0, "reset_done", done, 0);
    check(frame_err === 1'b0, "reset_ferr", frame_err, 0);
    check(busy === 1'b0, "reset_busy", busy, 0);
    rst = 1'b0;
    idle(5);
    check(busy === 1'b0, "busy_idle_after_reset", busy, 0);

    // 1: single 0x0B frame
    send_frame(8'h0B, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check(busy === 1'b0, "busy_after_frame", busy, 0);
    idle(10);

    // 2: back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    idle(10);

    // 3: glitch shorter than half a bit
    ser_in = 1'b0;
    repeat (5) @(negedge clk);
    idle(2 * CPB);
    check(busy === 1'b0, "busy_after_glitch", busy, 0);
    check(data === last_good, "data_after_glitch", data, last_good);

    // 4: framing error with the line held low, then a good frame
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check(busy === 1'b1, "busy_line_held_low", busy, 1);
    check(data === last_good, "data_kept_on_ferr", data, last_good);
    idle(5);
    check(busy === 1'b0, "busy_after_line_high", busy, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    idle(10);

    // 5: reset in the middle of data bit 4 (bits 4..7 high: no false start)
    fork
      send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
      begin
        repeat (1 + 5 * CPB + CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check(data === 8'h00, "rst_mid_data", data, 0);
        check(done === 1'b0, "rst_mid_done", done, 0);
        check(frame_err === 1'b0, "rst_mid_ferr", frame_err, 0);
        check(busy === 1'b0, "rst_mid_busy", busy, 0);
        rst = 1'b0;
        last_good = 8'h00;
      end
    join
    idle(10);
    check(busy === 1'b0, "busy_after_aborted_frame", busy, 0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    idle(10);

    // 6: loopback-style byte sequence from a transmitter model
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Randomized traffic with gaps of 0..3 idle cycles
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, 1'b1, 1'b0);
      idle($urandom_range(0, 3));
    end

    // Drain: every expected event must have appeared within the bound.
    waited = 0;
    while (sb_q.size() != 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
    idle(5);
    check(busy === 1'b0, "busy_at_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_rx
